// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Holds one retiring instruction and waits in WAIT for the load response.
// It extends load data and drives the register file write port combinationally.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic             m_regwrite,
    input  logic [1:0]       m_resultsrc,
    input  logic [2:0]       m_funct3,
    input  logic [4:0]       m_rd,
    input  logic [XLEN-1:0]  m_aluresult,
    input  logic [XLEN-1:0]  m_pcplus4,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             wb_busy,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic              r_valid_q, r_valid_d;
    logic              r_regwrite_q, r_regwrite_d;
    logic [1:0]        r_resultsrc_q, r_resultsrc_d;
    logic [2:0]        r_funct3_q, r_funct3_d;
    logic [4:0]        r_rd_q, r_rd_d;
    logic [XLEN-1:0]   r_alu_q, r_alu_d;
    logic [XLEN-1:0]   r_pc4_q, r_pc4_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic              waiting;
    logic              capture;
    logic              commit;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;
    logic [XLEN-1:0]   result;

    // Handshake, FSM next state, stage register next state and wait counter.
    always_comb begin
        waiting        = (state_q == StWait) && !dmem_rvalid;
        m_ready        = !waiting;
        capture        = m_valid && m_ready;
        // A held non-load retires in its single WB cycle; a held load retires on rvalid.
        commit         = r_valid_q && ((state_q == StIdle) || dmem_rvalid);

        state_d        = StIdle;
        r_valid_d      = r_valid_q;
        r_regwrite_d   = r_regwrite_q;
        r_resultsrc_d  = r_resultsrc_q;
        r_funct3_d     = r_funct3_q;
        r_rd_d         = r_rd_q;
        r_alu_d        = r_alu_q;
        r_pc4_d        = r_pc4_q;
        wait_cnt_d     = wait_cnt_q;

        if (waiting) begin
            state_d = StWait;
            if (wait_cnt_q != {CNT_W{1'b1}}) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end else begin
            r_valid_d = capture;
            if (capture) begin
                r_regwrite_d  = m_regwrite;
                r_resultsrc_d = m_resultsrc;
                r_funct3_d    = m_funct3;
                r_rd_d        = m_rd;
                r_alu_d       = m_aluresult;
                r_pc4_d       = m_pcplus4;
                if (m_resultsrc == 2'b01) begin
                    state_d = StWait;
                end
            end
        end
    end

    // State and stage register; reset drops any pending load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            r_valid_q     <= 1'b0;
            r_regwrite_q  <= 1'b0;
            r_resultsrc_q <= 2'b00;
            r_funct3_q    <= 3'b000;
            r_rd_q        <= 5'd0;
            r_alu_q       <= '0;
            r_pc4_q       <= '0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            r_valid_q     <= r_valid_d;
            r_regwrite_q  <= r_regwrite_d;
            r_resultsrc_q <= r_resultsrc_d;
            r_funct3_q    <= r_funct3_d;
            r_rd_q        <= r_rd_d;
            r_alu_q       <= r_alu_d;
            r_pc4_q       <= r_pc4_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Load lane selection and size/sign extension from the live memory word.
    always_comb begin
        case (r_alu_q[1:0])
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = r_alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Result select and register file write port; x0 is never written.
    always_comb begin
        case (r_resultsrc_q)
            2'b01:   result = ld_data;
            2'b10:   result = r_pc4_q;
            default: result = r_alu_q;
        endcase
        rf_we    = commit && r_regwrite_q && (r_rd_q != 5'd0);
        rf_waddr = r_valid_q ? r_rd_q : 5'd0;
        rf_wdata = r_valid_q ? result : '0;
        wb_busy  = (state_q == StWait);
        wait_cnt = wait_cnt_q;
    end

endmodule
